// File: rtl/src_pkg.sv
// rtl/src_pkg.sv - shared constants and FSM encoding for the SRC phase scheduler
// Purpose: default rate-conversion constants (L up, M down, stream count) and
//          the scheduler state encoding, imported by every file of the block.
// Ports:   none (package).
package src_pkg;

  localparam int L_DEF              = 160;  // interpolation factor / phase count
  localparam int L_LOG_DEF          = 8;    // phase index width, 2^L_LOG >= L
  localparam int M_DEF              = 147;  // decimation factor, M < L
  localparam int M_LOG_DEF          = 8;    // width of the M constant
  localparam int NR_STREAMS_DEF     = 16;   // interleaved streams per frame
  localparam int NR_STREAMS_LOG_DEF = 4;    // stream index width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/src_phase_scheduler_if.sv
// rtl/src_phase_scheduler_if.sv - command handshake between scheduler and input buffer
// Purpose: bundles the per-stream command bus (valid/ready plus payload).
// Ports:   master drives cmd_valid/cmd_shift/cmd_phase/cmd_stream/cmd_last and
//          samples cmd_ready; slave is the mirror image.
interface src_phase_scheduler_if #(
  parameter int L_LOG          = src_pkg::L_LOG_DEF,
  parameter int NR_STREAMS_LOG = src_pkg::NR_STREAMS_LOG_DEF
) ();

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_shift;
  logic [L_LOG-1:0]          cmd_phase;
  logic [NR_STREAMS_LOG-1:0] cmd_stream;
  logic                      cmd_last;

  modport master (
    output cmd_valid, cmd_shift, cmd_phase, cmd_stream, cmd_last,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_shift, cmd_phase, cmd_stream, cmd_last,
    output cmd_ready
  );

endinterface

// File: rtl/src_phase_acc.sv
// rtl/src_phase_acc.sv - polyphase phase accumulator and frame counter
// Purpose: holds the current coefficient phase (acc) and the frame index within
//          one L-frame period; steps both once per advance strobe.
// Ports:   clk, rst (sync, active-high); i_advance steps one frame;
//          o_phase = acc; o_frame_shift = this frame shifts a new sample in;
//          o_wrap = current frame is the last of the period (L-1).
module src_phase_acc
  import src_pkg::*;
#(
  parameter int L     = L_DEF,
  parameter int L_LOG = L_LOG_DEF,
  parameter int M     = M_DEF,
  parameter int M_LOG = M_LOG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  output logic [L_LOG-1:0] o_phase,
  output logic             o_frame_shift,
  output logic             o_wrap
);

  localparam logic [M_LOG-1:0] M_C = M_LOG'(M);

  logic [L_LOG-1:0] r_acc;
  logic [L_LOG-1:0] r_frame_idx;
  logic [L_LOG:0]   w_sum;
  logic [L_LOG:0]   w_next_full;

  // One extra bit so acc + M cannot overflow before the compare against L.
  assign w_sum         = {1'b0, r_acc} + (L_LOG+1)'(M_C);
  assign o_frame_shift = (w_sum >= (L_LOG+1)'(L));
  assign w_next_full   = o_frame_shift ? (w_sum - (L_LOG+1)'(L)) : w_sum;
  assign o_phase       = r_acc;
  assign o_wrap        = (r_frame_idx == L_LOG'(L - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_frame_idx <= '0;
    end else if (i_advance) begin
      r_acc       <= w_next_full[L_LOG-1:0];
      r_frame_idx <= o_wrap ? '0 : r_frame_idx + 1'b1;
    end
  end

endmodule

// File: rtl/src_phase_scheduler.sv
// rtl/src_phase_scheduler.sv - per-frame stream walker issuing shift/phase commands
// Purpose: for every output frame issues one command per stream (shift flag and
//          coefficient phase), then advances the phase accumulator.
// Ports:   clk, rst (sync, active-high); en run enable, honoured at frame
//          boundaries; cmd (master) command handshake to the input buffer;
//          frame_done pulses after a frame's last command is accepted;
//          period_wrap pulses with frame_done when the frame index wraps to 0.
module src_phase_scheduler
  import src_pkg::*;
#(
  parameter int L              = L_DEF,
  parameter int L_LOG          = L_LOG_DEF,
  parameter int M              = M_DEF,
  parameter int M_LOG          = M_LOG_DEF,
  parameter int NR_STREAMS     = NR_STREAMS_DEF,
  parameter int NR_STREAMS_LOG = NR_STREAMS_LOG_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  src_phase_scheduler_if.master cmd,
  output logic                  frame_done,
  output logic                  period_wrap
);

  state_e                    r_state;
  state_e                    w_next_state;
  logic [NR_STREAMS_LOG-1:0] r_stream;
  logic                      r_frame_done;
  logic                      r_period_wrap;

  logic                      w_is_last;
  logic                      w_hs;
  logic                      w_last_hs;
  logic [L_LOG-1:0]          w_phase;
  logic                      w_frame_shift;
  logic                      w_wrap;

  assign w_is_last = (r_stream == NR_STREAMS_LOG'(NR_STREAMS - 1));
  // cmd_ready outside ISSUE is ignored: no command is on offer there.
  assign w_hs      = (r_state == ST_ISSUE) && cmd.cmd_ready;
  assign w_last_hs = w_hs && w_is_last;

  src_phase_acc #(
    .L     (L),
    .L_LOG (L_LOG),
    .M     (M),
    .M_LOG (M_LOG)
  ) u_phase_acc (
    .clk           (clk),
    .rst           (rst),
    .i_advance     (w_last_hs),
    .o_phase       (w_phase),
    .o_frame_shift (w_frame_shift),
    .o_wrap        (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_stream      <= '0;
      r_frame_done  <= 1'b0;
      r_period_wrap <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_frame_done  <= w_last_hs;
      r_period_wrap <= w_last_hs && w_wrap;
      if (w_hs) begin
        r_stream <= w_is_last ? '0 : r_stream + 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    cmd.cmd_valid  = 1'b0;
    cmd.cmd_shift  = 1'b0;
    cmd.cmd_phase  = '0;
    cmd.cmd_stream = '0;
    cmd.cmd_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cmd.cmd_valid  = 1'b1;
        cmd.cmd_shift  = w_frame_shift;
        cmd.cmd_phase  = w_phase;
        cmd.cmd_stream = r_stream;
        cmd.cmd_last   = w_is_last;
        // en only matters once the frame's last command is taken; staying in
        // ISSUE gives back-to-back frames with no bubble.
        if (w_last_hs && !en) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign frame_done  = r_frame_done;
  assign period_wrap = r_period_wrap;

endmodule

// File: doc/src_phase_scheduler.md
Name: src_phase_scheduler

Overview:
- Sequencer for the multi-stream polyphase sample-rate converter input buffer (L=160 up, M=147 down, 16 interleaved streams).
- Per output frame, walks all streams in order and issues one command per stream: shift or no-shift for the buffer, and the polyphase coefficient phase for the filter.
- Replaces the hard-wired shift lookup table with a phase accumulator.
- Sits between the top-level control and the input buffer / coefficient ROM.

Parameters:
- L, 160, interpolation factor (number of polyphase phases).
- L_LOG, 8, width of phase index; must satisfy 2^L_LOG >= L.
- M, 147, decimation factor; M < L required.
- M_LOG, 8, width of M constant.
- NR_STREAMS, 16, number of interleaved streams.
- NR_STREAMS_LOG, 4, width of stream index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  run enable; sampled at frame boundaries only.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  buffer accepts command.
- cmd_shift  out  1  1 = shift new input sample in for this stream; 0 = reuse taps.
- cmd_phase  out  L_LOG  coefficient phase index, 0..L-1.
- cmd_stream  out  NR_STREAMS_LOG  stream index, 0..NR_STREAMS-1.
- cmd_last  out  1  high on the command for stream NR_STREAMS-1.
- frame_done  out  1  one-cycle pulse after the last command of a frame is accepted.
- period_wrap  out  1  one-cycle pulse, together with frame_done, when the frame index wraps L-1 -> 0.

Behaviour:
- Reset (rst high at a clk edge):
  - State = IDLE; acc = 0; frame_idx = 0; stream = 0.
  - All outputs 0.
  - Reset mid-frame aborts immediately; no partial-frame completion.
- Accumulator: sum = acc + M, computed L_LOG+1 bits wide.
  - frame_shift = (sum >= L).
  - next_acc = frame_shift ? sum - L : sum.
  - Matches a shift table entry of 1 iff floor(i*M/L) != floor((i+1)*M/L).
- State IDLE:
  - cmd_valid = 0.
  - If en = 1, go to ISSUE next cycle.
  - The first cmd_valid appears one cycle after en is sampled high.
- State ISSUE:
  - cmd_valid = 1.
  - cmd_phase = acc, cmd_shift = frame_shift, cmd_stream = stream, cmd_last = (stream == NR_STREAMS-1).
  - All cmd_* stable while cmd_valid && !cmd_ready.
- Handshake (cmd_valid && cmd_ready at an edge):
  - If not last: stream increments.
  - If last: stream <= 0; acc <= next_acc; frame_idx <= (frame_idx+1) mod L; frame_done pulses next cycle; period_wrap pulses too if frame_idx was L-1.
  - After the last command, stay in ISSUE if en = 1 (no bubble between frames), else go to IDLE.
- Throughput: one command per cycle while cmd_ready is held high.
- en deasserted mid-frame: the current frame completes; return to IDLE after its last handshake.
- cmd_ready high in IDLE: ignored.
- Invariants:
  - acc < L always.
  - Over any L consecutive frames, exactly M frames have shift = 1.
  - acc = 0 on every period_wrap.
  - Shift is identical for all streams within a frame.

Decomposition:
- Package src_pkg: L, L_LOG, M, M_LOG, NR_STREAMS, NR_STREAMS_LOG defaults; IDLE/ISSUE state encoding.
- One sub-module, src_phase_acc: holds acc and frame_idx, with an advance strobe; outputs phase, frame_shift, wrap.
- Top holds the FSM and stream counter.

Test Plan:
- Reset, en=1, cmd_ready=1 -> commands start 1 cycle later; frame 0: phase 0, shift 0, streams 0..15, cmd_last on stream 15; frame_done 1 cycle after.
- Continue running -> frame 1: phase 147, shift 1; frame 2: phase 134, shift 1; no idle cycle between frames.
- Run 160 frames -> exactly 147 frames with shift=1; period_wrap pulses once at frame 159 -> 0; phase back to 0.
- cmd_ready held low 5 cycles at stream 7 -> cmd_* stable, no advance; stream 8 issued after ready rises.
- en dropped at stream 3 -> streams 4..15 still issued; then IDLE with cmd_valid=0; re-enable resumes with the next frame's phase.
- rst asserted at stream 9 of frame 2 -> next cycle all outputs 0; after release and en, restart at phase 0, stream 0.
